// File: rtl/state_byte_display_if.sv
// Bus between the AES state source and the byte display feeder.
//
// Handshake: `load` is a single-cycle strobe with no ready; the feeder always
// accepts it, capturing `state` and restarting the scan. `bcd` is meaningful
// only while `bcd_valid` is high. `busy` covers the whole scan from the load
// edge onward. `done` pulses for one cycle when the scan completes.
interface state_byte_display_if;
  logic         load;
  logic [127:0] state;
  logic [11:0]  bcd;
  logic [3:0]   byte_index;
  logic         bcd_valid;
  logic         busy;
  logic         done;
  logic [1:0]   fsm_state;  // debug view of the controller state

  modport master (
    output load, state,
    input  bcd, byte_index, bcd_valid, busy, done, fsm_state
  );

  modport slave (
    input  load, state,
    output bcd, byte_index, bcd_valid, busy, done, fsm_state
  );
endinterface

// File: rtl/state_byte_display.sv
// Walks the 16 bytes of a captured AES state and converts each byte to three
// BCD digits with a bit-serial double-dabble engine. Each result is held for
// DWELL cycles before moving on to the next byte.
module state_byte_display #(
  parameter int unsigned DWELL = 4
) (
  input logic                 clk,
  input logic                 reset,
  state_byte_display_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } fsm_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  fsm_t         state_q, state_d;
  logic [127:0] shadow_q, shadow_d;
  logic [3:0]   idx_q, idx_d;
  logic [2:0]   bit_q, bit_d;
  logic [7:0]   dwell_q, dwell_d;
  logic [11:0]  scratch_q, scratch_d;
  logic [11:0]  bcd_q, bcd_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  logic [6:0]   base;
  logic [7:0]   cur_byte;
  logic         cur_bit;
  logic [11:0]  adj;
  logic [11:0]  conv;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Datapath for one double-dabble iteration: adjust digits, then shift in the next byte bit (MSB first).
  always_comb begin
    base     = {4'd15 - idx_q, 3'b000};
    cur_byte = shadow_q[base +: 8];
    cur_bit  = cur_byte[3'd7 - bit_q];
    adj      = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
    // Scratch never exceeds 0x255, so the bit shifted out of the top is always zero.
    conv     = (adj << 1) | {11'd0, cur_bit};
  end

  // Next-state and output logic; a load overrides whatever the FSM would do.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    bit_d     = bit_q;
    dwell_d   = dwell_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    valid_d   = valid_q;
    done_d    = 1'b0;

    case (state_q)
      CONVERT: begin
        scratch_d = conv;
        bit_d     = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          bcd_d   = conv;
          valid_d = 1'b1;
          dwell_d = 8'd0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (dwell_q == DWELL_LAST) begin
          if (idx_q != 4'd15) begin
            idx_d     = idx_q + 4'd1;
            valid_d   = 1'b0;
            scratch_d = 12'd0;
            bit_d     = 3'd0;
            state_d   = CONVERT;
          end else begin
            // Final byte stays on display after the scan ends.
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: ;
    endcase

    if (bus.load) begin
      shadow_d  = bus.state;
      idx_d     = 4'd0;
      bit_d     = 3'd0;
      scratch_d = 12'd0;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      state_d   = CONVERT;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      bit_q     <= '0;
      dwell_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      bit_q     <= bit_d;
      dwell_q   <= dwell_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.bcd        = bcd_q;
  assign bus.byte_index = idx_q;
  assign bus.bcd_valid  = valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_state_byte_display.sv
// Bench for state_byte_display: two instances (DWELL=4 and DWELL=1) share the
// same stimulus and are compared every cycle against a timing-based model,
// with hand-computed literal expectations at key edges.
module tb_state_byte_display;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic [127:0] state_in = '0;

  always #5 clk = ~clk;

  state_byte_display_if if4 ();
  state_byte_display_if if1 ();

  assign if4.load  = load;
  assign if4.state = state_in;
  assign if1.load  = load;
  assign if1.state = state_in;

  state_byte_display #(.DWELL(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  state_byte_display #(.DWELL(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // Derives outputs from elapsed time since the load edge: byte k owns
  // P cycles, its value appears 8 cycles in, and the scan ends at 16*P.
  function automatic int period(input int i);
    return (i == 0) ? 12 : 9;
  endfunction

  function automatic logic [11:0] to_bcd(input int b);
    return {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
  endfunction

  function automatic int byte_of(input logic [127:0] s, input int k);
    logic [127:0] t;
    t = s >> (8 * (15 - k));
    return int'(t[7:0]);
  endfunction

  bit           m_act  [2] = '{0, 0};
  int           m_t0   [2] = '{0, 0};
  logic [127:0] m_st   [2] = '{128'd0, 128'd0};
  logic [11:0]  m_bcd  [2] = '{12'd0, 12'd0};
  logic [3:0]   m_idx  [2] = '{4'd0, 4'd0};
  logic         m_val  [2] = '{1'b0, 1'b0};
  logic         m_busy [2] = '{1'b0, 1'b0};
  logic         m_done [2] = '{1'b0, 1'b0};

  always @(posedge clk or posedge reset) begin
    int n;
    int p;
    for (int i = 0; i < 2; i++) begin
      p = period(i);
      if (reset) begin
        m_act[i] = 0; m_bcd[i] = 0; m_idx[i] = 0;
        m_val[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_st[i] = 0;
      end else if (load) begin
        m_act[i] = 1; m_t0[i] = cyc + 1; m_st[i] = state_in;
        m_idx[i] = 0; m_val[i] = 0; m_busy[i] = 1; m_done[i] = 0;
      end else begin
        m_done[i] = 0;
        if (m_act[i]) begin
          n = cyc + 1 - m_t0[i];
          if (n == 16 * p) begin
            m_act[i] = 0; m_busy[i] = 0; m_done[i] = 1;
          end else begin
            m_idx[i] = 4'(n / p);
            m_val[i] = ((n % p) >= 8);
            if ((n % p) == 8) m_bcd[i] = to_bcd(byte_of(m_st[i], n / p));
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("d4.bcd",   32'(if4.bcd),        32'(m_bcd[0]));
      chk("d4.index", 32'(if4.byte_index), 32'(m_idx[0]));
      chk("d4.valid", 32'(if4.bcd_valid),  32'(m_val[0]));
      chk("d4.busy",  32'(if4.busy),       32'(m_busy[0]));
      chk("d4.done",  32'(if4.done),       32'(m_done[0]));
      chk("d1.bcd",   32'(if1.bcd),        32'(m_bcd[1]));
      chk("d1.index", 32'(if1.byte_index), 32'(m_idx[1]));
      chk("d1.valid", 32'(if1.bcd_valid),  32'(m_val[1]));
      chk("d1.busy",  32'(if1.busy),       32'(m_busy[1]));
      chk("d1.done",  32'(if1.done),       32'(m_done[1]));
    end
  end

  // ---------------- driver tasks ----------------
  // Return at the falling edge following rising edge number c.
  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Make `load` be sampled high at rising edge number c.
  task automatic load_at(input int c, input logic [127:0] st);
    goto(c - 1);
    load = 1'b1;
    state_in = st;
    goto(c);
    load = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".bcd"},   32'(if4.bcd),        32'h0);
    chk({tag, ".index"}, 32'(if4.byte_index), 32'h0);
    chk({tag, ".valid"}, 32'(if4.bcd_valid),  32'h0);
    chk({tag, ".busy"},  32'(if4.busy),       32'h0);
    chk({tag, ".done"},  32'(if4.done),       32'h0);
  endtask

  // ---------------- directed sequence ----------------
  int t0, t2, t3, t4, t5;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk_all_zero("por");

    // Run part of a scan, then reset asynchronously between edges.
    load_at(cyc + 2, PT);
    goto(cyc + 40);
    chk("pre_rst.busy", 32'(if4.busy), 32'h1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_all_zero("async_rst");
    chk("async_rst.d1bcd", 32'(if1.bcd), 32'h0);
    // A load pulse while reset is held must be ignored.
    @(negedge clk);
    load = 1'b1;
    state_in = PT;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    goto(cyc + 5);
    chk_all_zero("post_rst");

    // Plaintext scan, both dwell settings.
    t0 = cyc + 2;
    load_at(t0, PT);
    chk("pt.t0.busy",  32'(if4.busy),       32'h1);
    chk("pt.t0.valid", 32'(if4.bcd_valid),  32'h0);
    chk("pt.t0.index", 32'(if4.byte_index), 32'h0);
    goto(t0 + 8);
    chk("pt.b0.bcd",   32'(if4.bcd),       32'h000);
    chk("pt.b0.valid", 32'(if4.bcd_valid), 32'h1);
    chk("d1.b0.valid", 32'(if1.bcd_valid), 32'h1);
    goto(t0 + 9);
    chk("d1.b1.valid", 32'(if1.bcd_valid),  32'h0);
    chk("d1.b1.index", 32'(if1.byte_index), 32'h1);
    goto(t0 + 17);
    chk("d1.b1.bcd",   32'(if1.bcd), 32'h017);
    goto(t0 + 20);
    chk("pt.b1.bcd",   32'(if4.bcd), 32'h017);
    chk("model.b1",    32'(m_bcd[0]), 32'h017);
    goto(t0 + 116);
    chk("pt.b9.bcd",   32'(if4.bcd),        32'h153);
    chk("pt.b9.index", 32'(if4.byte_index), 32'h9);
    chk("model.b9",    32'(m_bcd[0]), 32'h153);
    goto(t0 + 143);
    chk("d1.end-1.done", 32'(if1.done), 32'h0);
    goto(t0 + 144);
    chk("d1.end.done", 32'(if1.done), 32'h1);
    chk("d1.end.busy", 32'(if1.busy), 32'h0);
    goto(t0 + 188);
    chk("pt.b15.bcd",  32'(if4.bcd), 32'h255);
    chk("model.b15",   32'(m_bcd[0]), 32'h255);
    goto(t0 + 191);
    chk("pt.pre.done", 32'(if4.done), 32'h0);
    goto(t0 + 192);
    chk("pt.end.done",  32'(if4.done),       32'h1);
    chk("pt.end.busy",  32'(if4.busy),       32'h0);
    chk("pt.end.index", 32'(if4.byte_index), 32'hf);
    chk("pt.end.valid", 32'(if4.bcd_valid),  32'h1);
    goto(t0 + 193);
    chk("pt.after.done", 32'(if4.done), 32'h0);
    chk("pt.after.bcd",  32'(if4.bcd),  32'h255);

    // Restart: plaintext scan interrupted by a ciphertext load 50 edges in.
    t2 = cyc + 3;
    load_at(t2, PT);
    t3 = t2 + 50;
    load_at(t3, CT);
    chk("rs.index", 32'(if4.byte_index), 32'h0);
    chk("rs.valid", 32'(if4.bcd_valid),  32'h0);
    chk("rs.busy",  32'(if4.busy),       32'h1);
    goto(t3 + 8);
    chk("ct.b0.bcd", 32'(if4.bcd), 32'h105);
    chk("model.ct0", 32'(m_bcd[0]), 32'h105);
    goto(t3 + 32);
    chk("ct.b2.bcd", 32'(if4.bcd), 32'h224);
    goto(t3 + 142);
    chk("rs.no_old_done", 32'(if4.done), 32'h0);
    goto(t3 + 188);
    chk("ct.b15.bcd", 32'(if4.bcd), 32'h090);
    goto(t3 + 192);
    chk("ct.end.done", 32'(if4.done), 32'h1);

    // Load on the very edge the final hold would end.
    t4 = cyc + 3;
    load_at(t4, PT);
    t5 = t4 + 192;
    load_at(t5, CT);
    chk("co.done",  32'(if4.done),       32'h0);
    chk("co.busy",  32'(if4.busy),       32'h1);
    chk("co.index", 32'(if4.byte_index), 32'h0);
    goto(t5 + 8);
    chk("co.b0.bcd", 32'(if4.bcd), 32'h105);
    goto(t5 + 192);
    chk("co.end.done", 32'(if4.done), 32'h1);

    // Back-to-back: load on the edge right after done.
    load_at(t5 + 193, PT);
    chk("b2b.busy",  32'(if4.busy),       32'h1);
    chk("b2b.done",  32'(if4.done),       32'h0);
    chk("b2b.index", 32'(if4.byte_index), 32'h0);
    goto(t5 + 193 + 10);
    chk("b2b.b0.bcd", 32'(if4.bcd), 32'h000);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d of %0d passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/state_byte_display.md
# state_byte_display

Sequential display feeder that sits downstream of the AES encrypt/decrypt cores and upstream of the seven-segment `DisplayDecoder` instances. It captures a 128-bit AES state on a load strobe and walks through its 16 bytes in order. Each byte is converted to three BCD digits with an iterative shift-add-3 (double-dabble) engine, and each result is held for a programmable dwell period. It replaces the single-byte combinational binary-to-BCD path when the full state must be shown on the three HEX digits.

## Interface
- `DWELL`, default 4: cycles each converted byte is held with `bcd_valid` high; legal range 1..255.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `load`  input  1  single-cycle strobe that captures `state` and starts or restarts a scan.
- `state`  input  128  AES state; byte 0 = `state[127:120]`, byte 15 = `state[7:0]`.
- `bcd`  output  12  `{hundreds, tens, ones}` of the current byte, 4 bits each.
- `byte_index`  output  4  index of the byte being converted or held.
- `bcd_valid`  output  1  high while `bcd` holds a completed conversion.
- `busy`  output  1  high from the load edge until the scan completes.
- `done`  output  1  one-cycle pulse when the hold of byte 15 ends.

## Operation
- **Shadow register.** The 128-bit shadow register is loaded from `state` only on `load`. Input changes at any other time are ignored.
- **FSM states:** IDLE, CONVERT, HOLD.
- **IDLE → CONVERT** on `load`:
  - Capture `state` into the shadow register.
  - `byte_index`=0, bit counter=0, scratch BCD=0.
  - `busy`=1, `bcd_valid`=0.
- **CONVERT** runs 8 iterations, one per cycle:
  - Each iteration adds 3 to every scratch digit ≥5, then shifts `{scratch, byte}` left by one. The next byte bit enters MSB first.
  - The 8th iteration writes its result straight to `bcd`, sets `bcd_valid`=1, and moves to HOLD.
- **HOLD** counts `DWELL` cycles. At the last one:
  - If `byte_index`<15: increment `byte_index`, clear `bcd_valid`, clear scratch, go to CONVERT.
  - If `byte_index`=15: go to IDLE, `busy`=0, `done`=1 for one cycle. `bcd`, `byte_index`=15 and `bcd_valid`=1 are retained.
- **Width rules.**
  - Scratch register is 12 bits and cannot overflow, since max 255 → 0x255.
  - Bit counter is 3 bits. Dwell counter is 8 bits.
- **`bcd` during CONVERT.** `bcd` holds the previous byte's value; only `bcd_valid` drops.
- **`load` while `busy`.** The scan restarts immediately with the new `state`:
  - `byte_index`=0, `bcd_valid`=0.
  - Any in-flight conversion is discarded.
- **`load` in the same cycle HOLD would complete byte 15.** `load` wins: `done` is not asserted and the new scan starts.
- **`reset` (asynchronous).** All outputs clear immediately, and the FSM goes to IDLE:
  - `bcd`=0, `byte_index`=0, `bcd_valid`=0, `busy`=0, `done`=0.
  - The shadow register clears.
  - A scan interrupted by reset does not resume.

## Timing
- Let `load` be sampled high at rising edge t0.
- **Edge t0:** `busy`=1, `bcd_valid`=0, `byte_index`=0.
- **Byte 0:** shifts occur at edges t0+1..t0+8. At t0+8, `bcd` is updated and `bcd_valid`=1.
- **Byte period:** P = 8+DWELL cycles.
- **Byte k:** `byte_index`=k from edge t0+k·P. `bcd` is valid from edge t0+k·P+8.
- **End of scan:** at edge t0+16·P, `busy` falls and `done` rises; `done` falls at the next edge.
- **Scan length** with DWELL=4: P=12, total 192 cycles.
- **Back-to-back scans:** a `load` at the edge after `done` starts the next scan with no dead cycle beyond IDLE.

## Test plan
- **Reset values and mid-scan reset.**
  - Assert `reset` asynchronously between clock edges → all outputs 0 immediately.
  - Pulse `load` with state=0x00112233445566778899aabbccddeeff, DWELL=4, then release reset → no outputs change until `load`.
- **Plaintext scan.** Same state and DWELL=4:
  - `bcd` at t0+8 is 0x000, at t0+8+12 is 0x017, at t0+8+9·12 (byte 9, 0x99) is 0x153, and at t0+8+15·12 (0xff) is 0x255.
  - `done` pulses at t0+192.
- **AES-128 ciphertext.** state=0x69c4e0d86a7b0430d8cdb78070b4c55a:
  - byte 0 = 0x105 (0x69), byte 2 = 0x224 (0xe0), byte 15 = 0x090 (0x5a).
- **Restart on reload.** Pulse `load` again at t0+50 with the ciphertext:
  - `byte_index` returns to 0 and `bcd_valid` falls at that edge.
  - `bcd`=0x105 eight edges later.
  - No `done` from the first scan.
- **Load coincident with final hold.** Pulse `load` on the edge t0+16·P → `done` stays 0, `busy` stays 1, `byte_index`=0.
- **DWELL=1.** `bcd_valid` is high for exactly one cycle per byte, and the scan length is 144 cycles.
